// File: rtl/axi4_lite_slave_write_responder_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) shared by the master driver and
// the slave responder.
interface axi4_lite_slave_write_responder_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi4_lite_slave_write_responder.sv
// AXI4-Lite slave write responder: independent AW and W acceptance FSMs with a
// programmable ready delay, one outstanding write, address decode into a small
// word-addressed register file and a registered B response.
module axi4_lite_slave_write_responder #(
  parameter int                       ADDRESS_WIDTH   = 32,
  parameter int                       DATA_WIDTH      = 32,
  parameter int                       DELAY_WIDTH     = 4,
  parameter int                       MAX_DELAY_VALUE = 15,
  parameter int                       NUM_REGS        = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR       = {ADDRESS_WIDTH{1'b0}}
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [DELAY_WIDTH-1:0]      delayForReadyCfg,
  axi4_lite_slave_write_responder_if.slave axi,
  input  logic [$clog2(NUM_REGS)-1:0] dbgIdx,
  output logic [DATA_WIDTH-1:0]       dbgData
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int WORD_W = ADDRESS_WIDTH - 2;

  // The ceiling can never exceed what the config field can express.
  localparam int DELAY_CAP = (MAX_DELAY_VALUE > ((2 ** DELAY_WIDTH) - 1)) ?
                             ((2 ** DELAY_WIDTH) - 1) : MAX_DELAY_VALUE;
  localparam logic [DELAY_WIDTH-1:0] DELAY_CAP_C  = DELAY_WIDTH'(DELAY_CAP);
  localparam logic [DELAY_WIDTH-1:0] DELAY_ZERO_C = {DELAY_WIDTH{1'b0}};
  localparam logic [DELAY_WIDTH-1:0] DELAY_ONE_C  = DELAY_WIDTH'(1);
  localparam logic [WORD_W-1:0]      NUM_REGS_C   = WORD_W'(NUM_REGS);
  localparam logic [IDX_W-1:0]       IDX_ZERO_C   = {IDX_W{1'b0}};

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_READY = 2'd2,
    ST_HELD  = 2'd3
  } chan_state_e;

  // AW channel state and payload
  chan_state_e              aw_state_q, aw_state_d;
  logic [DELAY_WIDTH-1:0]   aw_cnt_q, aw_cnt_d;
  logic                     aw_ready_q, aw_ready_d;
  logic [ADDRESS_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                     aw_nonsec_q, aw_nonsec_d;

  // W channel state and payload
  chan_state_e              w_state_q, w_state_d;
  logic [DELAY_WIDTH-1:0]   w_cnt_q, w_cnt_d;
  logic                     w_ready_q, w_ready_d;
  logic [DATA_WIDTH-1:0]    w_data_q, w_data_d;
  logic [STRB_W-1:0]        w_strb_q, w_strb_d;

  // B channel and storage
  logic                     bvalid_q, bvalid_d;
  logic [1:0]               bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0]    regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]    regs_d [NUM_REGS];

  // Decode / control
  logic [DELAY_WIDTH-1:0]   delay_sel_s;
  logic                     b_hs_s;
  logic                     commit_s;
  logic [WORD_W-1:0]        word_off_s;
  logic [IDX_W-1:0]         idx_s;
  logic                     misaligned_s;
  logic                     out_of_range_s;
  logic                     secure_viol_s;
  logic [1:0]               resp_s;
  logic                     wr_en_s;

  assign delay_sel_s = (delayForReadyCfg > DELAY_CAP_C) ? DELAY_CAP_C : delayForReadyCfg;
  assign b_hs_s      = bvalid_q & axi.bready;
  // Commit exactly once: both payloads held and no response pending yet.
  assign commit_s    = (aw_state_q == ST_HELD) && (w_state_q == ST_HELD) && !bvalid_q;

  // Word offset from the base; BASE_ADDR is expected to be word aligned.
  assign word_off_s     = aw_addr_q[ADDRESS_WIDTH-1:2] - BASE_ADDR[ADDRESS_WIDTH-1:2];
  assign idx_s          = word_off_s[IDX_W-1:0];
  assign misaligned_s   = (aw_addr_q[1:0] != 2'b00);
  assign out_of_range_s = (aw_addr_q < BASE_ADDR) || (word_off_s >= NUM_REGS_C);
  assign secure_viol_s  = (idx_s == IDX_ZERO_C) && aw_nonsec_q;

  assign axi.awready = aw_ready_q;
  assign axi.wready  = w_ready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign dbgData     = regs_q[dbgIdx];

  // AW acceptance FSM: delay, raise ready, latch address, hold until B done.
  always_comb begin
    aw_state_d  = aw_state_q;
    aw_cnt_d    = aw_cnt_q;
    aw_addr_d   = aw_addr_q;
    aw_nonsec_d = aw_nonsec_q;
    case (aw_state_q)
      ST_IDLE: begin
        if (axi.awvalid) begin
          aw_cnt_d   = delay_sel_s;
          aw_state_d = (delay_sel_s == DELAY_ZERO_C) ? ST_READY : ST_DELAY;
        end else begin
          aw_cnt_d   = DELAY_ZERO_C;
        end
      end
      ST_DELAY: begin
        if (!axi.awvalid) begin
          aw_cnt_d   = DELAY_ZERO_C;
          aw_state_d = ST_IDLE;
        end else begin
          aw_cnt_d   = aw_cnt_q - DELAY_ONE_C;
          aw_state_d = (aw_cnt_q == DELAY_ONE_C) ? ST_READY : ST_DELAY;
        end
      end
      ST_READY: begin
        if (axi.awvalid && aw_ready_q) begin
          aw_addr_d   = axi.awaddr;
          aw_nonsec_d = axi.awprot[1];
          aw_state_d  = ST_HELD;
        end else if (!axi.awvalid) begin
          aw_state_d  = ST_IDLE;
        end else begin
          aw_state_d  = ST_READY;
        end
      end
      ST_HELD: begin
        if (b_hs_s) begin
          aw_state_d = ST_IDLE;
        end else begin
          aw_state_d = ST_HELD;
        end
      end
      default: begin
        aw_state_d = ST_IDLE;
        aw_cnt_d   = DELAY_ZERO_C;
      end
    endcase
    aw_ready_d = (aw_state_d == ST_READY);
  end

  // W acceptance FSM: same protocol as AW, latching data and strobes.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    case (w_state_q)
      ST_IDLE: begin
        if (axi.wvalid) begin
          w_cnt_d   = delay_sel_s;
          w_state_d = (delay_sel_s == DELAY_ZERO_C) ? ST_READY : ST_DELAY;
        end else begin
          w_cnt_d   = DELAY_ZERO_C;
        end
      end
      ST_DELAY: begin
        if (!axi.wvalid) begin
          w_cnt_d   = DELAY_ZERO_C;
          w_state_d = ST_IDLE;
        end else begin
          w_cnt_d   = w_cnt_q - DELAY_ONE_C;
          w_state_d = (w_cnt_q == DELAY_ONE_C) ? ST_READY : ST_DELAY;
        end
      end
      ST_READY: begin
        if (axi.wvalid && w_ready_q) begin
          w_data_d  = axi.wdata;
          w_strb_d  = axi.wstrb;
          w_state_d = ST_HELD;
        end else if (!axi.wvalid) begin
          w_state_d = ST_IDLE;
        end else begin
          w_state_d = ST_READY;
        end
      end
      ST_HELD: begin
        if (b_hs_s) begin
          w_state_d = ST_IDLE;
        end else begin
          w_state_d = ST_HELD;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
        w_cnt_d   = DELAY_ZERO_C;
      end
    endcase
    w_ready_d = (w_state_d == ST_READY);
  end

  // Response decode; alignment beats range, range beats protection.
  always_comb begin
    resp_s  = RESP_OKAY;
    wr_en_s = 1'b0;
    if (misaligned_s) begin
      resp_s = RESP_SLVERR;
    end else if (out_of_range_s) begin
      resp_s = RESP_DECERR;
    end else if (secure_viol_s) begin
      resp_s = RESP_SLVERR;
    end else begin
      resp_s  = RESP_OKAY;
      wr_en_s = 1'b1;
    end
  end

  // Byte-lane merge of the held write data into the addressed register.
  always_comb begin
    regs_d = regs_q;
    if (commit_s && wr_en_s) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb_q[i]) begin
          regs_d[idx_s][8*i +: 8] = w_data_q[8*i +: 8];
        end else begin
          regs_d[idx_s][8*i +: 8] = regs_q[idx_s][8*i +: 8];
        end
      end
    end else begin
      regs_d = regs_q;
    end
  end

  // B channel: raise on commit, hold stable until bready, then clear.
  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (commit_s) begin
      bvalid_d = 1'b1;
      bresp_d  = resp_s;
    end else if (b_hs_s) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end else begin
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
    end
  end

  // State, payload and register-file storage; reset discards everything.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_state_q  <= ST_IDLE;
      aw_cnt_q    <= DELAY_ZERO_C;
      aw_ready_q  <= 1'b0;
      aw_addr_q   <= {ADDRESS_WIDTH{1'b0}};
      aw_nonsec_q <= 1'b0;
      w_state_q   <= ST_IDLE;
      w_cnt_q     <= DELAY_ZERO_C;
      w_ready_q   <= 1'b0;
      w_data_q    <= {DATA_WIDTH{1'b0}};
      w_strb_q    <= {STRB_W{1'b0}};
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      aw_state_q  <= aw_state_d;
      aw_cnt_q    <= aw_cnt_d;
      aw_ready_q  <= aw_ready_d;
      aw_addr_q   <= aw_addr_d;
      aw_nonsec_q <= aw_nonsec_d;
      w_state_q   <= w_state_d;
      w_cnt_q     <= w_cnt_d;
      w_ready_q   <= w_ready_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      regs_q      <= regs_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_write_responder.sv
// Self-checking bench for the AXI4-Lite write responder: table vectors,
// hand-written timing/backpressure/reset sequences and randomized writes
// checked against a register-file reference model.
module tb_axi4_lite_slave_write_responder;

  localparam int NREGS = 16;

  logic        aclk;
  logic        areset;
  logic [4:0]  cfg;
  logic [3:0]  dbg_idx;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_regs [NREGS];

  axi4_lite_slave_write_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_slave_write_responder #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DELAY_WIDTH(5),
    .MAX_DELAY_VALUE(15), .NUM_REGS(NREGS), .BASE_ADDR(32'h0)
  ) dut (
    .aclk(aclk), .areset(areset), .delayForReadyCfg(cfg),
    .axi(bus), .dbgIdx(dbg_idx), .dbgData(dbg_data)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference response from the decode rules (register 0 secure-only).
  function automatic logic [1:0] ref_resp(input logic [31:0] addr, input logic [2:0] prot);
    longint off;
    off = longint'(addr);
    if (off % 4 != 0) return 2'b10;
    if (off < 0 || off / 4 >= NREGS) return 2'b11;
    if (off / 4 == 0 && prot[1]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr / 4);
    for (int b = 0; b < 4; b++)
      if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
  endfunction

  task automatic dbg_check(input string name, input int idx, input logic [31:0] exp);
    dbg_idx = 4'(idx);
    #1;
    check(name, dbg_data, exp);
  endtask

  task automatic idle_inputs();
    bus.awvalid = 1'b0; bus.awaddr = 32'h0; bus.awprot = 3'b000;
    bus.wvalid  = 1'b0; bus.wdata  = 32'h0; bus.wstrb  = 4'h0;
    bus.bready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge aclk);
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    for (int i = 0; i < NREGS; i++) model_regs[i] = 32'h0;
  endtask

  // One complete write; checks ready latency, response timing and stability.
  task automatic run_write(input logic [31:0] addr, input logic [2:0] prot,
                           input logic [31:0] data, input logic [3:0] strb,
                           input logic [4:0] cfg_v, input int aw_start, input int w_start,
                           input int b_wait, input bit keep_aw, input logic [31:0] addr2,
                           output logic [1:0] resp, output int aw_hs, output int w_hs,
                           output int bv_cyc);
    int d, b_low, last;
    bit aw_done, w_done, b_done, quiet, b_stable;
    d = (cfg_v > 5'd15) ? 15 : int'(cfg_v);
    aw_done = 0; w_done = 0; b_done = 0; quiet = 1; b_stable = 1;
    aw_hs = -1; w_hs = -1; bv_cyc = -1; b_low = 0; resp = 2'bxx;
    cfg = cfg_v;
    for (int cyc = 0; cyc < 200 && !b_done; cyc++) begin
      @(negedge aclk);
      if (!aw_done) begin
        bus.awvalid = (cyc >= aw_start); bus.awaddr = addr; bus.awprot = prot;
      end else if (keep_aw) begin
        bus.awvalid = 1'b1; bus.awaddr = addr2; bus.awprot = 3'b000;
      end else begin
        bus.awvalid = 1'b0;
      end
      if (!w_done) begin
        bus.wvalid = (cyc >= w_start); bus.wdata = data; bus.wstrb = strb;
      end else begin
        bus.wvalid = 1'b0;
      end
      bus.bready = (b_wait == 0) || (b_low >= b_wait);
      #1;
      if ((aw_done && bus.awready) || (w_done && bus.wready)) quiet = 0;
      if (!aw_done && bus.awvalid && bus.awready) begin aw_done = 1; aw_hs = cyc; end
      if (!w_done && bus.wvalid && bus.wready) begin w_done = 1; w_hs = cyc; end
      if (bus.bvalid) begin
        if (bv_cyc < 0) begin bv_cyc = cyc; resp = bus.bresp; end
        else if (bus.bresp !== resp) b_stable = 0;
        if (bus.bready) b_done = 1; else b_low++;
      end
    end
    last = (aw_hs > w_hs) ? aw_hs : w_hs;
    check("b_handshake_done", b_done, 1'b1);
    check("aw_ready_latency", aw_hs - aw_start, d + 1);
    check("w_ready_latency", w_hs - w_start, d + 1);
    check("bvalid_cycle", bv_cyc, last + 2);
    check("ready_low_while_held", quiet, 1'b1);
    if (b_wait > 0) check("b_stable_under_backpressure", b_stable, 1'b1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [4:0]  cfg;
    logic [1:0]  exp_resp;
    int          chk_idx;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [10];

  initial begin : main
    logic [1:0]  resp;
    int          aw_hs, w_hs, bv;
    logic [31:0] a, dt;
    logic [2:0]  pr;
    logic [3:0]  sb;
    logic [4:0]  cf;
    bit          saw_b;

    vecs[0] = '{addr:32'h4,        prot:3'b000, data:32'hDEADBEEF, strb:4'hF, cfg:5'd0, exp_resp:2'b00, chk_idx:1,  exp_val:32'hDEADBEEF};
    vecs[1] = '{addr:32'h6,        prot:3'b000, data:32'h12121212, strb:4'hF, cfg:5'd0, exp_resp:2'b10, chk_idx:1,  exp_val:32'hDEADBEEF};
    vecs[2] = '{addr:32'h40,       prot:3'b000, data:32'h34343434, strb:4'hF, cfg:5'd0, exp_resp:2'b11, chk_idx:0,  exp_val:32'h0};
    vecs[3] = '{addr:32'h0,        prot:3'b010, data:32'h12345678, strb:4'hF, cfg:5'd0, exp_resp:2'b10, chk_idx:0,  exp_val:32'h0};
    vecs[4] = '{addr:32'h0,        prot:3'b000, data:32'h12345678, strb:4'hF, cfg:5'd0, exp_resp:2'b00, chk_idx:0,  exp_val:32'h12345678};
    vecs[5] = '{addr:32'h8,        prot:3'b000, data:32'h11223344, strb:4'hF, cfg:5'd1, exp_resp:2'b00, chk_idx:2,  exp_val:32'h11223344};
    vecs[6] = '{addr:32'h8,        prot:3'b000, data:32'hAABBCCDD, strb:4'h5, cfg:5'd0, exp_resp:2'b00, chk_idx:2,  exp_val:32'h11BB33DD};
    vecs[7] = '{addr:32'h8,        prot:3'b000, data:32'hFFFFFFFF, strb:4'h0, cfg:5'd0, exp_resp:2'b00, chk_idx:2,  exp_val:32'h11BB33DD};
    vecs[8] = '{addr:32'h3C,       prot:3'b011, data:32'hCAFEF00D, strb:4'hF, cfg:5'd2, exp_resp:2'b00, chk_idx:15, exp_val:32'hCAFEF00D};
    vecs[9] = '{addr:32'hFFFFFFFC, prot:3'b000, data:32'h99999999, strb:4'hF, cfg:5'd0, exp_resp:2'b11, chk_idx:15, exp_val:32'hCAFEF00D};

    areset = 1'b1; cfg = 5'd0; dbg_idx = 4'd0;
    idle_inputs();
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    for (int i = 0; i < NREGS; i++) model_regs[i] = 32'h0;
    #1;
    check("reset_awready", bus.awready, 1'b0);
    check("reset_wready", bus.wready, 1'b0);
    check("reset_bvalid", bus.bvalid, 1'b0);
    check("reset_bresp", bus.bresp, 2'b00);
    dbg_check("reset_reg1", 1, 32'h0);

    // Table-driven vectors: simultaneous AW/W, bready already high.
    for (int i = 0; i < 10; i++) begin
      run_write(vecs[i].addr, vecs[i].prot, vecs[i].data, vecs[i].strb, vecs[i].cfg,
                0, 0, 0, 1'b0, 32'h0, resp, aw_hs, w_hs, bv);
      check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
      if (ref_resp(vecs[i].addr, vecs[i].prot) == 2'b00) model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      dbg_check($sformatf("vec%0d_reg", i), vecs[i].chk_idx, vecs[i].exp_val);
    end

    // W first with delay 3, AW five cycles later.
    run_write(32'h20, 3'b000, 32'h5A5A5A5A, 4'hF, 5'd3, 5, 0, 0, 1'b0, 32'h0, resp, aw_hs, w_hs, bv);
    check("late_aw_w_hs", w_hs, 4);
    check("late_aw_aw_hs", aw_hs, 9);
    check("late_aw_bvalid", bv, 11);
    model_write(32'h20, 32'h5A5A5A5A, 4'hF);
    dbg_check("late_aw_reg8", 8, 32'h5A5A5A5A);

    // Config above the ceiling is clamped to 15.
    run_write(32'h24, 3'b000, 32'h0BADF00D, 4'hF, 5'd20, 0, 0, 0, 1'b0, 32'h0, resp, aw_hs, w_hs, bv);
    check("clamp_aw_hs", aw_hs, 16);
    check("clamp_bvalid", bv, 18);
    model_write(32'h24, 32'h0BADF00D, 4'hF);

    // Backpressure on B with a second address already waiting.
    run_write(32'h10, 3'b000, 32'h01020304, 4'hF, 5'd0, 0, 0, 10, 1'b1, 32'h14, resp, aw_hs, w_hs, bv);
    check("bp_bresp", resp, 2'b00);
    check("bp_bvalid", bv, 3);
    model_write(32'h10, 32'h01020304, 4'hF);
    run_write(32'h14, 3'b000, 32'h0A0B0C0D, 4'hF, 5'd0, 0, 0, 0, 1'b0, 32'h0, resp, aw_hs, w_hs, bv);
    check("bp_second_aw_hs", aw_hs, 1);
    model_write(32'h14, 32'h0A0B0C0D, 4'hF);
    dbg_check("bp_reg4", 4, 32'h01020304);
    dbg_check("bp_reg5", 5, 32'h0A0B0C0D);

    // Reset in the middle of a write: AW accepted, W never sent.
    cfg = 5'd0;
    saw_b = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      bus.awvalid = 1'b1; bus.awaddr = 32'h4; bus.awprot = 3'b000;
      #1;
      if (bus.awready) break;
    end
    check("rst_mid_aw_accepted", bus.awready, 1'b1);
    @(negedge aclk);
    idle_inputs();
    areset = 1'b1;
    #1;
    check("rst_mid_awready", bus.awready, 1'b0);
    check("rst_mid_wready", bus.wready, 1'b0);
    check("rst_mid_bvalid", bus.bvalid, 1'b0);
    for (int i = 0; i < NREGS; i++) model_regs[i] = 32'h0;
    dbg_check("rst_mid_reg1", 1, 32'h0);
    dbg_check("rst_mid_reg2", 2, 32'h0);
    @(negedge aclk);
    areset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      bus.wvalid = 1'b1; bus.wdata = 32'h77777777; bus.wstrb = 4'hF; bus.bready = 1'b1;
      #1;
      if (bus.bvalid) saw_b = 1;
      if (bus.wready) bus.wvalid = 1'b1;
    end
    check("rst_w_alone_no_bvalid", saw_b, 1'b0);
    dbg_check("rst_after_reg0", 0, 32'h0);
    dbg_check("rst_after_reg15", 15, 32'h0);
    do_reset();

    // Randomized writes against the reference model.
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 9))
        6:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        7:       a = 32'h40 + 32'($urandom_range(0, 255) * 4);
        8:       a = 32'h0;
        9:       a = $urandom;
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      pr = 3'($urandom_range(0, 7));
      dt = $urandom;
      sb = 4'($urandom_range(0, 15));
      cf = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 3));
      run_write(a, pr, dt, sb, cf, $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 3), 1'b0, 32'h0, resp, aw_hs, w_hs, bv);
      check($sformatf("rand%0d_bresp", t), resp, ref_resp(a, pr));
      if (ref_resp(a, pr) == 2'b00) model_write(a, dt, sb);
      begin
        int k;
        k = $urandom_range(0, NREGS - 1);
        dbg_check($sformatf("rand%0d_reg%0d", t, k), k, model_regs[k]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
